cpu_instr_seq: RTL and testbench

Parametrised instruction-frame sequencer for CPU checking benches. It drives the opcode and operand bytes of one instruction onto the CPU data-in bus during the correct machine cycles, and tracks T-states and M-cycles. It checks fetch addresses against the expected PC and flags any change to protected registers after the first M1. It sits between the formal/simulation bench and the CPU core. It generalises the single-byte, fixed two-M-cycle register-load check to instructions of 1..MAX_BYTES bytes and 1..MAX_MCYC M-cycles.

---
 rtl/cpu_seq_pkg.sv | 33 +++
 rtl/cpu_instr_seq_stab.sv | 49 ++++
 rtl/cpu_instr_seq.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_instr_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU instruction-frame sequencer:
// sequencer states, T-state codes, register indices and an instruction byte picker.
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

  localparam logic [1:0] T1 = 2'd0;
  localparam logic [1:0] T2 = 2'd1;
  localparam logic [1:0] T3 = 2'd2;
  localparam logic [1:0] T4 = 2'd3;

  localparam int unsigned REG_B = 0;
  localparam int unsigned REG_C = 1;
  localparam int unsigned REG_D = 2;
  localparam int unsigned REG_E = 3;
  localparam int unsigned REG_H = 4;
  localparam int unsigned REG_L = 5;
  localparam int unsigned REG_A = 6;

  // Widest instruction vector the 2-bit length field can address.
  localparam int unsigned INSTR_VEC_BYTES = 4;

  function automatic logic [7:0] instr_byte(input logic [8*INSTR_VEC_BYTES-1:0] instr,
                                            input logic [1:0]                   k);
    return instr[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/cpu_instr_seq_stab.sv
// Register stability checker: snapshots the monitored CPU registers on snap_en and
// reports a mismatch pulse while chk_en is high and any protected register has moved.
module cpu_instr_seq_stab #(
  parameter int NREG = 7
) (
  input  logic              clk,
  input  logic              snap_en,
  input  logic              chk_en,
  input  logic [8*NREG-1:0] regs,
  input  logic [NREG-1:0]   reg_mask,
  input  logic              chk_sp_f,
  input  logic [23:0]       sp_f,
  output logic              mismatch
);

  logic [8*NREG-1:0] regs_snap_q, regs_snap_d;
  logic [23:0]       sp_f_snap_q, sp_f_snap_d;
  logic [NREG-1:0]   reg_diff;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    regs_snap_d = regs_snap_q;
    sp_f_snap_d = sp_f_snap_q;
    if (snap_en) begin
      regs_snap_d = regs;
      sp_f_snap_d = sp_f;
    end
  end

  always_comb begin
    reg_diff = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_diff[i] = regs[8*i +: 8] != regs_snap_q[8*i +: 8];
    end
    mismatch = chk_en && ((|(reg_diff & reg_mask)) ||
                          (chk_sp_f && (sp_f != sp_f_snap_q)));
  end

  // NOTE: snapshot storage has no reset: it is always written at M1 T4 before
  // the check window opens, so a reset would only cost routing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    regs_snap_q <= regs_snap_d;
    sp_f_snap_q <= sp_f_snap_d;
  end

endmodule

// File: rtl/cpu_instr_seq.sv
// Instruction-frame sequencer: drives opcode/operand bytes onto din, tracks M/T cycles,
// and flags register disturbance. Define CPU_INSTR_SEQ_ADR_CHECK_EN to check fetch addresses.
module cpu_instr_seq
  import cpu_seq_pkg::*;
#(
  parameter int MAX_BYTES = 3,
  parameter int MAX_MCYC  = 6,
  parameter int NREG      = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             instr_len,
  input  logic [2:0]             mcyc_len,
  input  logic [8*MAX_BYTES-1:0] instr,
  input  logic [15:0]            pc_start,
  input  logic [7:0]             fill,
  input  logic [15:0]            adr,
  input  logic [8*NREG-1:0]      regs,
  input  logic [NREG-1:0]        reg_mask,
  input  logic                   chk_sp_f,
  input  logic [23:0]            sp_f,
  output logic [7:0]             din,
  output logic                   busy,
  output logic [2:0]             mcyc,
  output logic [1:0]             tcyc,
  output logic                   done,
  output logic                   cfg_err,
  output logic                   adr_err,
  output logic                   stab_err
);

  seq_state_e state_q, state_d;
  logic [2:0] mcyc_q, mcyc_d;
  logic [1:0] tcyc_q, tcyc_d;
  logic       cfg_err_q, cfg_err_d;
  logic       stab_err_q, stab_err_d;

  logic [1:0]             instr_len_q, instr_len_d;
  logic [2:0]             mcyc_len_q, mcyc_len_d;
  logic [8*MAX_BYTES-1:0] instr_q, instr_d;
  logic [NREG-1:0]        reg_mask_q, reg_mask_d;
  logic                   chk_sp_f_q, chk_sp_f_d;

  logic       cfg_ok;
  logic       accept;
  logic       fetch_cyc;
  logic [1:0] byte_idx;
  logic       snap_en;
  logic       chk_en;
  logic       stab_mis;

  always_comb begin
    cfg_ok = (instr_len != 2'd0) &&
             (int'(instr_len) <= MAX_BYTES) &&
             (mcyc_len >= {1'b0, instr_len}) &&
             (int'(mcyc_len) <= MAX_MCYC);
  end

  assign accept    = (state_q == ST_IDLE) && start && cfg_ok;
  assign fetch_cyc = (state_q == ST_RUN) && (mcyc_q <= {1'b0, instr_len_q});
  assign byte_idx  = 2'(mcyc_q - 3'd1);
  assign snap_en   = (state_q == ST_RUN) && (mcyc_q == 3'd1) && (tcyc_q == T4);
  assign chk_en    = ((state_q == ST_RUN) && (mcyc_q != 3'd1)) || (state_q == ST_NEXT);

  always_comb begin
    instr_len_d = instr_len_q;
    mcyc_len_d  = mcyc_len_q;
    instr_d     = instr_q;
    reg_mask_d  = reg_mask_q;
    chk_sp_f_d  = chk_sp_f_q;
    if (accept) begin
      instr_len_d = instr_len;
      mcyc_len_d  = mcyc_len;
      instr_d     = instr;
      reg_mask_d  = reg_mask;
      chk_sp_f_d  = chk_sp_f;
    end
  end

  always_comb begin
    state_d    = state_q;
    mcyc_d     = mcyc_q;
    tcyc_d     = tcyc_q;
    cfg_err_d  = cfg_err_q;
    stab_err_d = stab_err_q | stab_mis;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d    = ST_RUN;
            mcyc_d     = 3'd1;
            tcyc_d     = T1;
            cfg_err_d  = 1'b0;
            stab_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        tcyc_d = tcyc_q + 2'd1;
        if (tcyc_q == T4) begin
          if (mcyc_q == mcyc_len_q) begin
            state_d = ST_NEXT;
            mcyc_d  = 3'd1;
          end else begin
            mcyc_d = mcyc_q + 3'd1;
          end
        end
      end
      ST_NEXT: begin
        tcyc_d = tcyc_q + 2'd1;
        if (tcyc_q == T4) begin
          state_d = ST_DONE;
          mcyc_d  = 3'd0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction bytes are presented for the whole fetch M-cycle; fill otherwise.
  always_comb begin
    din = fill;
    if (fetch_cyc) begin
      din = instr_byte((8*INSTR_VEC_BYTES)'(instr_q), byte_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mcyc_q     <= 3'd0;
      tcyc_q     <= T1;
      cfg_err_q  <= 1'b0;
      stab_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcyc_q     <= mcyc_d;
      tcyc_q     <= tcyc_d;
      cfg_err_q  <= cfg_err_d;
      stab_err_q <= stab_err_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_len_q <= instr_len_d;
    mcyc_len_q  <= mcyc_len_d;
    instr_q     <= instr_d;
    reg_mask_q  <= reg_mask_d;
    chk_sp_f_q  <= chk_sp_f_d;
  end

  cpu_instr_seq_stab #(
    .NREG(NREG)
  ) u_stab (
    .clk      (clk),
    .snap_en  (snap_en),
    .chk_en   (chk_en),
    .regs     (regs),
    .reg_mask (reg_mask_q),
    .chk_sp_f (chk_sp_f_q),
    .sp_f     (sp_f),
    .mismatch (stab_mis)
  );

`ifdef CPU_INSTR_SEQ_ADR_CHECK_EN
  logic [15:0] pc_q, pc_d;
  logic [15:0] adr_exp;
  logic        adr_chk;
  logic        adr_err_q, adr_err_d;

  always_comb begin
    pc_d    = accept ? pc_start : pc_q;
    adr_chk = 1'b0;
    adr_exp = pc_q + 16'(mcyc_q) - 16'd1;
    if (tcyc_q == T1) begin
      if (fetch_cyc) begin
        adr_chk = 1'b1;
      end else if (state_q == ST_NEXT) begin
        adr_chk = 1'b1;
        adr_exp = pc_q + 16'(instr_len_q);
      end
    end
    adr_err_d = adr_err_q | (adr_chk && (adr != adr_exp));
    if (accept) begin
      adr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (reset) begin
      adr_err_q <= 1'b0;
    end else begin
      adr_err_q <= adr_err_d;
    end
  end

  assign adr_err = adr_err_q;
`else
  logic unused_adr;
  assign unused_adr = ^{adr, pc_start};
  assign adr_err    = 1'b0;
`endif

  assign busy     = (state_q == ST_RUN) || (state_q == ST_NEXT);
  assign done     = (state_q == ST_DONE);
  assign mcyc     = mcyc_q;
  assign tcyc     = tcyc_q;
  assign cfg_err  = cfg_err_q;
  assign stab_err = stab_err_q;

endmodule

// File: tb/tb_cpu_instr_seq.sv
// Self-checking bench for cpu_instr_seq: per-cycle comparison against a frame model
// computed from cycle arithmetic (M = (c-1)/4+1, T = (c-1)%4).
module tb_cpu_instr_seq;
  import cpu_seq_pkg::*;

`ifdef CPU_INSTR_SEQ_ADR_CHECK_EN
  localparam bit ADR_EN = 1'b1;
`else
  localparam bit ADR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  instr_len;
  logic [2:0]  mcyc_len;
  logic [23:0] instr;
  logic [15:0] pc_start;
  logic [7:0]  fill;
  logic [15:0] adr;
  logic [55:0] regs;
  logic [6:0]  reg_mask;
  logic        chk_sp_f;
  logic [23:0] sp_f;
  logic [7:0]  din;
  logic        busy;
  logic [2:0]  mcyc;
  logic [1:0]  tcyc;
  logic        done;
  logic        cfg_err;
  logic        adr_err;
  logic        stab_err;

  int          n_cmp = 0;
  int          n_mis = 0;
  string       cur_test = "init";
  bit          cfg_m, adr_m, stab_m;
  logic [7:0]  cur_r [7];
  logic [23:0] cur_sp;

  always #5 clk = ~clk;

  cpu_instr_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .instr_len (instr_len),
    .mcyc_len  (mcyc_len),
    .instr     (instr),
    .pc_start  (pc_start),
    .fill      (fill),
    .adr       (adr),
    .regs      (regs),
    .reg_mask  (reg_mask),
    .chk_sp_f  (chk_sp_f),
    .sp_f      (sp_f),
    .din       (din),
    .busy      (busy),
    .mcyc      (mcyc),
    .tcyc      (tcyc),
    .done      (done),
    .cfg_err   (cfg_err),
    .adr_err   (adr_err),
    .stab_err  (stab_err)
  );

  task automatic drive_regs();
    for (int i = 0; i < 7; i++) regs[8*i +: 8] = cur_r[i];
    sp_f = cur_sp;
  endtask

  // One frame from its start cycle (c = 0) through DONE (c = n+1), or until the
  // cycle in which reset is asserted (rst_c). -1 disables pert_c/bad_c/rst_c.
  task automatic run_frame(input logic [1:0] ilen, input logic [2:0] mlen,
                           input logic [23:0] ins, input logic [15:0] pc,
                           input logic [6:0] mask, input logic chk,
                           input int pert_c, input int pert_r, input int bad_c,
                           input bit stray, input int rst_c);
    int          n;
    int          m;
    int          t;
    logic [7:0]  fv;
    logic [7:0]  snap [7];
    logic [23:0] snap_sp;
    logic [15:0] exp_a;
    bit          a_chk;
    logic [6:0]  exp_st;
    logic [7:0]  exp_din;
    n  = 4 * (int'(mlen) + 1);
    fv = 8'($urandom);
    for (int c = 0; c <= n + 1; c++) begin
      @(posedge clk);
      #1;
      m     = (c >= 1) ? (c - 1) / 4 + 1 : 0;
      t     = (c >= 1) ? (c - 1) % 4 : 0;
      fill  = fv;
      reset = (c == rst_c);
      if (c == 0) begin
        start = 1'b1; instr_len = ilen; mcyc_len = mlen; instr = ins;
        pc_start = pc; reg_mask = mask; chk_sp_f = chk;
      end else begin
        start     = (c == n + 1) ? stray : (stray ? 1'($urandom_range(0, 1)) : 1'b0);
        instr_len = 2'($urandom); mcyc_len = 3'($urandom); instr = 24'($urandom);
        pc_start  = 16'($urandom); reg_mask = 7'($urandom); chk_sp_f = 1'($urandom);
      end
      if (c == pert_c) begin
        if (pert_r == 7) cur_sp ^= 24'($urandom_range(1, 24'hFF_FFFF));
        else cur_r[pert_r] ^= 8'($urandom_range(1, 255));
      end
      drive_regs();
      a_chk = 1'b0;
      exp_a = 16'($urandom);
      if (c >= 1 && c <= n && t == 0) begin
        if (m <= int'(ilen)) begin
          a_chk = 1'b1; exp_a = pc + 16'(m - 1);
        end else if (m == int'(mlen) + 1) begin
          a_chk = 1'b1; exp_a = pc + 16'(ilen);
        end
      end
      adr = (c == bad_c) ? (exp_a ^ 16'h0001) : exp_a;
      @(negedge clk);
      if (c == 0) begin
        exp_st = 7'd0; exp_din = fv;
      end else if (c <= n) begin
        exp_st  = {1'b1, 1'b0, 3'((m <= int'(mlen)) ? m : 1), 2'(t)};
        exp_din = (m <= int'(ilen)) ? ins[8*(m-1) +: 8] : fv;
      end else begin
        exp_st = {1'b0, 1'b1, 3'd0, 2'd0}; exp_din = fv;
      end
      n_cmp++;
      if ({busy, done, mcyc, tcyc} !== exp_st) begin
        n_mis++;
        $display("FAIL %s status c=%0d got busy/done/mcyc/tcyc=%b expected %b",
                 cur_test, c, {busy, done, mcyc, tcyc}, exp_st);
      end
      n_cmp++;
      if (din !== exp_din) begin
        n_mis++;
        $display("FAIL %s din c=%0d got %h expected %h", cur_test, c, din, exp_din);
      end
      n_cmp++;
      if ({cfg_err, adr_err, stab_err} !== {cfg_m, adr_m, stab_m}) begin
        n_mis++;
        $display("FAIL %s flags c=%0d got cfg/adr/stab=%b expected %b",
                 cur_test, c, {cfg_err, adr_err, stab_err}, {cfg_m, adr_m, stab_m});
      end
      if (c == 0) {cfg_m, adr_m, stab_m} = 3'b000;
      if (c == 4) begin
        for (int i = 0; i < 7; i++) snap[i] = cur_r[i];
        snap_sp = cur_sp;
      end
      if (c >= 5 && c <= n) begin
        for (int i = 0; i < 7; i++) if (mask[i] && cur_r[i] != snap[i]) stab_m = 1'b1;
        if (chk && cur_sp != snap_sp) stab_m = 1'b1;
      end
      if (ADR_EN && a_chk && adr != exp_a) adr_m = 1'b1;
      if (c == rst_c) begin
        {cfg_m, adr_m, stab_m} = 3'b000;
        break;
      end
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'($urandom); fill = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({busy, done, mcyc, tcyc, cfg_err, adr_err, stab_err} !== 10'd0) begin
        n_mis++;
        $display("FAIL reset state k=%0d got %b expected all zero", k,
                 {busy, done, mcyc, tcyc, cfg_err, adr_err, stab_err});
      end
      n_cmp++;
      if (din !== fill) begin
        n_mis++;
        $display("FAIL reset din got %h expected %h", din, fill);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    {cfg_m, adr_m, stab_m} = 3'b000;
  endtask

  task automatic test_ld_b_c();
    cur_test = "ld_b_c";
    run_frame(2'd1, 3'd1, 24'h000041, 16'h0100, 7'h7F, 1'b1, -1, 0, -1, 1'b0, -1);
  endtask

  task automatic test_three_byte();
    cur_test = "three_byte_wrap";
    run_frame(2'd3, 3'd4, 24'h123421, 16'hFFFF, 7'h7F, 1'b0, -1, 0, -1, 1'b0, -1);
    cur_test = "three_byte_bad_next_adr";
    run_frame(2'd3, 3'd4, 24'h123421, 16'hFFFF, 7'h7F, 1'b0, -1, 0, 17, 1'b0, -1);
    cur_test = "two_byte_wrap_bad_fetch";
    run_frame(2'd2, 3'd2, 24'h00AB3E, 16'hFFFF, 7'h00, 1'b0, -1, 0, 5, 1'b0, -1);
  endtask

  task automatic test_stab();
    cur_test = "stab_d_m2t2";
    run_frame(2'd2, 3'd3, 24'h00550E, 16'h2000, 7'h7F, 1'b0, 6, REG_D, -1, 1'b0, -1);
    cur_test = "stab_unmasked";
    run_frame(2'd1, 3'd3, 24'h000078, 16'h2000, 7'h7B, 1'b0, 9, REG_D, -1, 1'b0, -1);
    cur_test = "stab_before_snap";
    run_frame(2'd1, 3'd2, 24'h000047, 16'h2000, 7'h7F, 1'b1, 4, REG_A, -1, 1'b0, -1);
    cur_test = "stab_last_next";
    run_frame(2'd1, 3'd1, 24'h000040, 16'h2000, 7'h7F, 1'b0, 8, REG_B, -1, 1'b0, -1);
    cur_test = "stab_sp_f_on";
    run_frame(2'd1, 3'd2, 24'h000033, 16'h3000, 7'h00, 1'b1, 7, 7, -1, 1'b0, -1);
    cur_test = "stab_sp_f_off";
    run_frame(2'd1, 3'd2, 24'h000033, 16'h3000, 7'h00, 1'b0, 7, 7, -1, 1'b0, -1);
  endtask

  task automatic test_cfg_err();
    cur_test = "cfg_err";
    for (int il = 0; il < 4; il++) begin
      for (int ml = 0; ml < 8; ml++) begin
        if (il >= 1 && il <= 3 && ml >= il && ml <= 6) continue;
        @(posedge clk);
        #1;
        start = 1'b1; instr_len = 2'(il); mcyc_len = 3'(ml); reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_m = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, cfg_err} !== {1'b0, cfg_m}) begin
          n_mis++;
          $display("FAIL cfg_err len=%0d mcyc=%0d got busy/cfg=%b expected %b",
                   il, ml, {busy, cfg_err}, {1'b0, cfg_m});
        end
      end
    end
    cur_test = "cfg_err_cleared";
    run_frame(2'd2, 3'd2, 24'h0012C3, 16'h4000, 7'h3F, 1'b0, -1, 0, -1, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    cur_test = "reset_mid_frame";
    run_frame(2'd2, 3'd3, 24'h0077DD, 16'h5000, 7'h7F, 1'b0, 5, REG_E, 5, 1'b0, 7);
    cur_test = "start_after_reset";
    run_frame(2'd1, 3'd2, 24'h0000C9, 16'h5100, 7'h7F, 1'b0, -1, 0, -1, 1'b0, -1);
  endtask

  task automatic test_stray_start();
    cur_test = "stray_start";
    run_frame(2'd2, 3'd3, 24'h0099C3, 16'h6000, 7'h55, 1'b1, -1, 0, -1, 1'b1, -1);
    run_frame(2'd3, 3'd6, 24'hBEEFCD, 16'hFFFE, 7'h7F, 1'b0, 12, REG_H, -1, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    int il;
    int ml;
    cur_test = "back_to_back_random";
    for (int k = 0; k < 24; k++) begin
      il = $urandom_range(1, 3);
      ml = $urandom_range(il, 6);
      run_frame(2'(il), 3'(ml), 24'($urandom), 16'($urandom), 7'($urandom), 1'($urandom),
                $urandom_range(0, 4 * (ml + 1)), $urandom_range(0, 7),
                $urandom_range(0, 4 * (ml + 1)), 1'($urandom), -1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_len = 2'd0; mcyc_len = 3'd0; instr = '0;
    pc_start = '0; fill = '0; adr = '0; reg_mask = '0; chk_sp_f = 1'b0;
    for (int i = 0; i < 7; i++) cur_r[i] = 8'($urandom);
    cur_sp = 24'($urandom);
    drive_regs();
    test_reset();
    test_ld_b_c();
    test_three_byte();
    test_stab();
    test_cfg_err();
    test_reset_mid();
    test_stray_start();
    test_back_to_back();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
